// File: rtl/mac_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// mac_sequencer_pkg
// Shared types and default widths for the neuron MAC sequencer and its
// post-processing stage.
// ----------------------------------------------------------------------------
package mac_sequencer_pkg;

    // Default widths; modules expose these as overridable parameters
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_ACC_WIDTH  = 18;
    localparam int unsigned DEF_ADDR_WIDTH = 6;

    // Largest value representable on the default output width
    localparam int unsigned OUT_MAX = (1 << DEF_DATA_WIDTH) - 1;

    // Sequencer state encoding
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_ACT   = 3'd4,
        ST_OUT   = 3'd5
    } state_e;

endpackage : mac_sequencer_pkg

// File: rtl/mac_sequencer_post_proc.sv
// ----------------------------------------------------------------------------
// mac_post_proc
// Combinational neuron output stage: (acc + bias) >> SHIFT, saturated to the
// unsigned DATA_WIDTH range. The add is done one bit wider than the
// accumulator so the carry can never be lost.
//
// Ports:
//   acc      in   ACC_WIDTH   accumulator value from the MAC
//   bias     in   ACC_WIDTH   unsigned bias
//   result_c out  DATA_WIDTH  saturated result (combinational)
// ----------------------------------------------------------------------------
module mac_post_proc
    import mac_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int unsigned SHIFT      = 0
) (
    input  logic [ACC_WIDTH-1:0]  acc,
    input  logic [ACC_WIDTH-1:0]  bias,
    output logic [DATA_WIDTH-1:0] result_c
);

    localparam int unsigned SUM_WIDTH = ACC_WIDTH + 1;
    localparam logic [SUM_WIDTH-1:0] SAT_MAX =
        SUM_WIDTH'((64'd1 << DATA_WIDTH) - 64'd1);

    logic [SUM_WIDTH-1:0] sum_c;
    logic [SUM_WIDTH-1:0] shifted_c;

    // Bias add, scale, clamp
    always_comb begin
        sum_c     = SUM_WIDTH'(acc) + SUM_WIDTH'(bias);
        shifted_c = sum_c >> SHIFT;
        result_c  = (shifted_c > SAT_MAX) ? DATA_WIDTH'(SAT_MAX)
                                          : shifted_c[DATA_WIDTH-1:0];
    end

endmodule : mac_post_proc

// File: rtl/mac_sequencer.sv
// ----------------------------------------------------------------------------
// mac_sequencer
// Runs one neuron's dot product on a shared MAC: clears the MAC, streams N
// address pairs to the activation/weight memories (1-cycle read latency),
// enables the MAC in step with the returned data, then adds bias, shifts,
// saturates and offers the result on a valid/ready port.
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   start/n_inputs/bias   evaluation request, sampled only in IDLE
//   busy                  high from the cycle after an accepted start until
//                         the output handshake completes
//   rd_en/rd_addr         shared read strobe/address to both memories
//   act_data/wgt_data     memory read data, valid 1 cycle after rd_en
//   mac_rst/mac_en        MAC synchronous clear / accumulate enable
//   mac_a/mac_b           MAC operands, straight pass-through of read data
//   mac_result            MAC accumulator
//   out_valid/out_ready/out_data  neuron output handshake
// ----------------------------------------------------------------------------
module mac_sequencer
    import mac_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned SHIFT      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   n_inputs,
    input  logic [ACC_WIDTH-1:0]  bias,
    output logic                  busy,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] act_data,
    input  logic [DATA_WIDTH-1:0] wgt_data,
    output logic                  mac_rst,
    output logic                  mac_en,
    output logic [DATA_WIDTH-1:0] mac_a,
    output logic [DATA_WIDTH-1:0] mac_b,
    input  logic [ACC_WIDTH-1:0]  mac_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] N_MAX = CNT_WIDTH'(64'd1 << ADDR_WIDTH);

    state_e                 state_q,     state_d;
    logic [CNT_WIDTH-1:0]   n_q,         n_d;
    logic [ACC_WIDTH-1:0]   bias_q,      bias_d;
    logic [ADDR_WIDTH-1:0]  rd_addr_q,   rd_addr_d;
    logic                   rd_en_q,     rd_en_d;
    logic                   rd_valid_q;
    logic                   busy_q,      busy_d;
    logic                   mac_rst_q,   mac_rst_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  out_data_q,  out_data_d;

    logic                   last_issue_c;
    logic [DATA_WIDTH-1:0]  post_c;

    // Bias add / shift / saturate on the live accumulator
    mac_post_proc #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .SHIFT      (SHIFT)
    ) u_post_proc (
        .acc      (mac_result),
        .bias     (bias_q),
        .result_c (post_c)
    );

    // rd_addr doubles as the issue counter k; n_q >= 1 whenever ISSUE is entered
    assign last_issue_c = ({1'b0, rd_addr_q} == (n_q - CNT_WIDTH'(1)));

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        bias_d     = bias_q;
        rd_addr_d  = rd_addr_q;
        rd_en_d    = 1'b0;
        out_data_d = out_data_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                    n_d     = (n_inputs > N_MAX) ? N_MAX : n_inputs;
                    bias_d  = bias;
                end
            end
            ST_CLEAR: begin
                rd_addr_d = '0;
                if (n_q == '0) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                    rd_en_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (last_issue_c) begin
                    state_d = ST_WAIT;
                end else begin
                    rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                    rd_en_d   = 1'b1;
                end
            end
            // Last accumulate lands at the end of this cycle
            ST_WAIT: begin
                state_d = ST_ACT;
            end
            ST_ACT: begin
                state_d    = ST_OUT;
                out_data_d = post_c;
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d      = (state_d != ST_IDLE);
        mac_rst_d   = (state_d == ST_CLEAR);
        out_valid_d = (state_d == ST_OUT);
    end

    // State and output registers; MAC held clear while in reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            bias_q      <= '0;
            rd_addr_q   <= '0;
            rd_en_q     <= 1'b0;
            rd_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            mac_rst_q   <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            bias_q      <= bias_d;
            rd_addr_q   <= rd_addr_d;
            rd_en_q     <= rd_en_d;
            rd_valid_q  <= rd_en_q;
            busy_q      <= busy_d;
            mac_rst_q   <= mac_rst_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign busy      = busy_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign mac_rst   = mac_rst_q;
    assign mac_en    = rd_valid_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Operands go to the MAC untouched
    assign mac_a = act_data;
    assign mac_b = wgt_data;

endmodule : mac_sequencer
